// File: rtl/intr_ctl.sv
// intr_ctl: parametrised interrupt controller on the io register bus.
//   Collects NSRC peripheral lines, qualifies each with enable, edge/level
//   mode, polarity and a 2-bit priority, compares against a global
//   threshold and drives one registered interrupt request into execute.
//   Software claims the highest-priority eligible source by reading CLAIM
//   and releases it by writing its id back to the same register.
//
// Ports:
//   clk        system clock
//   reset      synchronous, active-high reset
//   src        raw source lines (may be asynchronous to clk)
//   interrupt  registered request to the core
//   io_addr    register word index
//   io_write   one-cycle write strobe
//   io_read    one-cycle read strobe (CLAIM read has a side effect)
//   io_wdata   write data
//   io_rdata   combinational read data
//
// Register map (bits at or above NSRC read 0, writes to them are dropped):
//   0 PENDING (RO, W1C on edge sources)   1 ENABLE    2 MODE (1=edge)
//   3 POLARITY (1=active low)             4 CLAIM/COMPLETE
//   5 THRESHOLD                           6 PRIO_LO   7 PRIO_HI

// Per-source front end: polarity fold, 2-flop synchronizer, edge detect
// and the latched pend bit used in edge mode.
module intr_ctl_src (
    input  logic clk,
    input  logic reset,
    input  logic src,
    input  logic polarity,
    input  logic mode,
    input  logic w1c,
    input  logic claim_clr,
    output logic pending
);
    logic s1, s2, s3, pend;

    always_ff @(posedge clk) begin
        if (reset) begin
            s1   <= 1'b0;
            s2   <= 1'b0;
            s3   <= 1'b0;
            pend <= 1'b0;
        end else begin
            s1 <= src ^ polarity;
            s2 <= s1;
            s3 <= s2;
            // Level sources never latch; an edge arriving in the same cycle
            // as a clear must not be lost, so the set has precedence.
            if (!mode)
                pend <= 1'b0;
            else if (s2 && !s3)
                pend <= 1'b1;
            else if (w1c || claim_clr)
                pend <= 1'b0;
        end
    end

    assign pending = mode ? pend : s2;
endmodule

module intr_ctl #(
    parameter int NSRC      = 8,
    parameter int RV        = 16,
    parameter int PRIO_BITS = 2
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [NSRC-1:0] src,
    output logic            interrupt,
    input  logic [3:0]      io_addr,
    input  logic            io_write,
    input  logic            io_read,
    input  logic [RV-1:0]   io_wdata,
    output logic [RV-1:0]   io_rdata
);
    // Sources packed per 16-bit priority word.
    localparam int PER_WORD = 16 / PRIO_BITS;

    typedef struct packed {
        logic       valid;
        logic [3:0] id;
    } claim_t;

    logic [NSRC-1:0]                 enable, mode, polarity, insvc;
    logic [NSRC-1:0]                 pending, eligible, w1c, claim_clr;
    logic [NSRC-1:0][PRIO_BITS-1:0]  prio;
    logic [PRIO_BITS-1:0]            threshold;
    logic [PRIO_BITS-1:0]            best_p;
    claim_t                          win;
    logic                            do_claim, do_cmpl, wr_pend;
    logic [15:0]                     prio_lo, prio_hi;

    assign wr_pend  = io_write && (io_addr == 4'd0);
    assign do_cmpl  = io_write && (io_addr == 4'd4);
    assign do_claim = io_read  && (io_addr == 4'd4) && win.valid;

    for (genvar g = 0; g < NSRC; g++) begin : g_src
        assign w1c[g]       = wr_pend && io_wdata[g] && mode[g];
        assign claim_clr[g] = do_claim && (win.id == 4'(g)) && mode[g];
        assign eligible[g]  = pending[g] && enable[g] && !insvc[g] &&
                              (prio[g] > threshold);

        intr_ctl_src u_src (
            .clk       (clk),
            .reset     (reset),
            .src       (src[g]),
            .polarity  (polarity[g]),
            .mode      (mode[g]),
            .w1c       (w1c[g]),
            .claim_clr (claim_clr[g]),
            .pending   (pending[g])
        );
    end

    // Winner select: strictly-greater compare while scanning upward keeps
    // the lowest index on a priority tie.
    always_comb begin
        win    = '0;
        best_p = '0;
        for (int i = 0; i < NSRC; i++) begin
            if (eligible[i] && (!win.valid || prio[i] > best_p)) begin
                win.valid = 1'b1;
                win.id    = 4'(i);
                best_p    = prio[i];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            enable    <= '0;
            mode      <= '0;
            polarity  <= '0;
            threshold <= '0;
            prio      <= '0;
            insvc     <= '0;
            interrupt <= 1'b0;
        end else begin
            interrupt <= |eligible;
            if (io_write) begin
                case (io_addr)
                    4'd1:    enable    <= io_wdata[NSRC-1:0];
                    4'd2:    mode      <= io_wdata[NSRC-1:0];
                    4'd3:    polarity  <= io_wdata[NSRC-1:0];
                    4'd5:    threshold <= io_wdata[PRIO_BITS-1:0];
                    default: ;
                endcase
            end
            for (int i = 0; i < NSRC; i++) begin
                if (io_write && io_addr == ((i < PER_WORD) ? 4'd6 : 4'd7))
                    prio[i] <= io_wdata[(PRIO_BITS*i) % 16 +: PRIO_BITS];
                // Ids >= NSRC match no slot, so out-of-range completes drop.
                if (do_claim && win.id == 4'(i))
                    insvc[i] <= 1'b1;
                else if (do_cmpl && io_wdata[3:0] == 4'(i))
                    insvc[i] <= 1'b0;
            end
        end
    end

    always_comb begin
        prio_lo = '0;
        prio_hi = '0;
        for (int i = 0; i < NSRC; i++) begin
            if (i < PER_WORD)
                prio_lo[(PRIO_BITS*i) % 16 +: PRIO_BITS] = prio[i];
            else
                prio_hi[(PRIO_BITS*i) % 16 +: PRIO_BITS] = prio[i];
        end
    end

    always_comb begin
        io_rdata = '0;
        case (io_addr)
            4'd0: io_rdata[NSRC-1:0] = pending;
            4'd1: io_rdata[NSRC-1:0] = enable;
            4'd2: io_rdata[NSRC-1:0] = mode;
            4'd3: io_rdata[NSRC-1:0] = polarity;
            4'd4: begin
                io_rdata[15]  = win.valid;
                io_rdata[3:0] = win.valid ? win.id : 4'd0;
            end
            4'd5: io_rdata[PRIO_BITS-1:0] = threshold;
            4'd6: io_rdata[15:0] = prio_lo;
            4'd7: io_rdata[15:0] = prio_hi;
            default: ;
        endcase
    end
endmodule
